// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-input valid/ready streaming multiplexer with one registered
// output stage. Arbitration is round-robin (RR_MODE=1) or fixed priority with
// the lowest index winning (RR_MODE=0). The accepted word is held until the
// consumer takes it, and the register can reload in the same cycle it drains.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   per-channel valid (bit i = channel i)
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, at most one bit high (depends on out_ready)
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_sel    index of the channel that out_data came from
//   out_ready  consumer accepts the word when out_valid && out_ready
module stream_arb_mux #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned N_IN    = 4,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned SEL_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic load_en;
  logic grant_any;
  logic xfer;
  int   grant_idx;

  // Register may load when empty or when its word is being taken this cycle.
  assign load_en = !reset && (!out_valid_q || out_ready);

  // Search valid channels starting at the pointer (or 0 in fixed priority),
  // ascending with wrap; the first valid channel found wins.
  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = 0;
    for (int k = 0; k < int'(N_IN); k++) begin
      idx = k + ((RR_MODE != 0) ? int'(ptr_q) : 0);
      if (idx >= int'(N_IN)) idx = idx - int'(N_IN);
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign xfer = load_en && grant_any;

  // One-hot ready to the granted channel only.
  always_comb begin : p_ready
    in_ready = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      in_ready[k] = xfer && (grant_idx == k);
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin : p_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      // Drain without a new grant clears valid but keeps data/sel.
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = in_data[grant_idx*int'(WIDTH) +: WIDTH];
        out_sel_d  = SEL_W'(grant_idx);
        if (RR_MODE != 0) begin
          ptr_d = SEL_W'(((grant_idx + 1) == int'(N_IN)) ? 0 : (grant_idx + 1));
        end
      end
    end
  end

  // State registers with synchronous reset; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed bench for stream_arb_mux (WIDTH=8, N_IN=4).
// One round-robin instance is driven from a per-cycle vector table; a second
// fixed-priority instance is exercised by a short hand-written sequence.
module tb_stream_arb_mux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned SEL_W = 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic                  rst;
  logic [N_IN-1:0]       v;
  logic [N_IN*WIDTH-1:0] d;
  logic [N_IN-1:0]       rdy;
  logic                  ov;
  logic [WIDTH-1:0]      od;
  logic [SEL_W-1:0]      os;
  logic                  ordy;

  // Fixed-priority instance signals
  logic                  fp_rst;
  logic [N_IN-1:0]       fp_v;
  logic [N_IN*WIDTH-1:0] fp_d;
  logic [N_IN-1:0]       fp_rdy;
  logic                  fp_ov;
  logic [WIDTH-1:0]      fp_od;
  logic [SEL_W-1:0]      fp_os;
  logic                  fp_ordy;

  stream_arb_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(rst), .in_valid(v), .in_data(d), .in_ready(rdy),
    .out_valid(ov), .out_data(od), .out_sel(os), .out_ready(ordy)
  );

  stream_arb_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(fp_rst), .in_valid(fp_v), .in_data(fp_d), .in_ready(fp_rdy),
    .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os), .out_ready(fp_ordy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic                  rst;
    logic [N_IN-1:0]       v;
    logic [N_IN*WIDTH-1:0] d;
    logic                  ordy;
    logic [N_IN-1:0]       e_rdy;  // in_ready before the edge
    logic                  e_ov;   // outputs after the edge
    logic [WIDTH-1:0]      e_od;
    logic [SEL_W-1:0]      e_os;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [3:0] vv, logic [31:0] dd, logic rd,
                              logic [3:0] er, logic eov, logic [7:0] eod, logic [1:0] eos);
    vec_t x;
    x.rst = r; x.v = vv; x.d = dd; x.ordy = rd;
    x.e_rdy = er; x.e_ov = eov; x.e_od = eod; x.e_os = eos;
    return x;
  endfunction

  // Producer rule on the RR instance: a pending valid word holds until taken.
  logic [N_IN-1:0]       pend_q;
  logic [N_IN*WIDTH-1:0] pd_q;
  initial pend_q = '0;
  always @(posedge clk) begin
    for (int i = 0; i < int'(N_IN); i++) begin
      if (pend_q[i]) begin
        chk($sformatf("producer_hold_ch%0d", i),
            {23'd0, v[i], d[i*8 +: 8]}, {23'd0, 1'b1, pd_q[i*8 +: 8]});
      end
    end
    pend_q <= rst ? (v & ~rdy) : (v & ~rdy);
    pd_q   <= d;
  end

  initial begin
    rst = 1'b1; v = '0; d = '0; ordy = 1'b0;
    fp_rst = 1'b1; fp_v = '0; fp_d = '0; fp_ordy = 1'b0;

    // Reset with all channels valid
    vt.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0));
    vt.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0));
    // Round-robin rotation, channels retiring after their last grant
    vt.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 0));
    vt.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1));
    vt.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 2));
    vt.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 3));
    vt.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 0));
    vt.push_back(mk(0, 4'b1110, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1));
    vt.push_back(mk(0, 4'b1100, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 2));
    vt.push_back(mk(0, 4'b1000, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 3));
    // Drain with no new word keeps data/sel
    vt.push_back(mk(0, 4'b0000, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'hA3, 3));
    // Backpressure: 5C from ch2 held for 5 stall cycles
    vt.push_back(mk(0, 4'b0100, 32'hA35CA1A0, 0, 4'b0100, 1, 8'h5C, 2));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 4'b1000, 32'hC35CA1A0, 0, 4'b0000, 1, 8'h5C, 2));
    // Release: ch3 loads in the same cycle the old word drains
    vt.push_back(mk(0, 4'b1000, 32'hC35CA1A0, 1, 4'b1000, 1, 8'hC3, 3));
    vt.push_back(mk(0, 4'b0000, 32'hC35CA1A0, 1, 4'b0000, 0, 8'hC3, 3));
    // Sparse: ch1 transfer (pointer -> 2), idle, then ch0+ch3 -> ch3 first
    vt.push_back(mk(0, 4'b0010, 32'hC35CB1A0, 1, 4'b0010, 1, 8'hB1, 1));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 4'b0000, 32'hC35CB1A0, 1, 4'b0000, 0, 8'hB1, 1));
    vt.push_back(mk(0, 4'b1001, 32'hD35CB1D0, 1, 4'b1000, 1, 8'hD3, 3));
    vt.push_back(mk(0, 4'b0001, 32'hD35CB1D0, 1, 4'b0001, 1, 8'hD0, 0));
    // Reset mid-stall (pointer was 1): held word discarded, pointer back to 0
    vt.push_back(mk(0, 4'b0100, 32'hD3E2B1D0, 0, 4'b0000, 1, 8'hD0, 0));
    vt.push_back(mk(1, 4'b0100, 32'hD3E2B1D0, 0, 4'b0000, 0, 8'h00, 0));
    // Pointer 0 picks ch0 over ch2 (pointer 1 would pick ch2)
    vt.push_back(mk(0, 4'b0101, 32'hD3E2B1F0, 0, 4'b0001, 1, 8'hF0, 0));
    vt.push_back(mk(0, 4'b0100, 32'hD3E2B1F0, 1, 4'b0100, 1, 8'hE2, 2));
    vt.push_back(mk(0, 4'b0000, 32'hD3E2B1F0, 1, 4'b0000, 0, 8'hE2, 2));

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; v = vt[i].v; d = vt[i].d; ordy = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), {28'd0, rdy}, {28'd0, vt[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, ov}, {31'd0, vt[i].e_ov});
      chk($sformatf("v%0d_out_data", i), {24'd0, od}, {24'd0, vt[i].e_od});
      chk($sformatf("v%0d_out_sel", i), {30'd0, os}, {30'd0, vt[i].e_os});
    end

    // Fixed priority: 1010 held, ch1 wins every cycle, ch3 never ready
    @(negedge clk);
    fp_rst = 1'b1; fp_v = 4'b1010; fp_d = 32'h33222211; fp_ordy = 1'b1;
    @(negedge clk);
    #1;
    chk("fp_reset_ready", {28'd0, fp_rdy}, 32'd0);
    chk("fp_reset_valid", {31'd0, fp_ov}, 32'd0);
    @(negedge clk);
    fp_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("fp_c%0d_in_ready", c), {28'd0, fp_rdy}, 32'h2);
      @(posedge clk);
      #1;
      chk($sformatf("fp_c%0d_out_valid", c), {31'd0, fp_ov}, 32'd1);
      chk($sformatf("fp_c%0d_out_data", c), {24'd0, fp_od}, 32'h22);
      chk($sformatf("fp_c%0d_out_sel", c), {30'd0, fp_os}, 32'd1);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
